// File: rtl/sync_to_click_tx.sv
// Clocked valid/ready stream into a 2-phase bundled-data click channel.
// Words are buffered in a small FIFO; the returning ack is synchronized.
module sync_to_click_tx #(
    parameter int DATA_WIDTH  = 7,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH:0]          in_data,
    output logic                         out_req,
    output logic [DATA_WIDTH:0]          out_data,
    input  logic                         out_ack,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK
    } state_e;

    logic [DATA_WIDTH:0]    mem_q [DEPTH];
    logic [PW-1:0]          wptr_q;
    logic [PW-1:0]          rptr_q;
    logic [LW-1:0]          level_q;
    logic [LW-1:0]          level_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   push;
    logic                   pop;
    logic                   req_q;
    logic                   req_d;
    logic                   err_q;
    logic                   err_d;
    logic [DATA_WIDTH:0]    data_q;
    logic [DATA_WIDTH:0]    data_d;
    state_e                 state_q;
    state_e                 state_d;

    assign in_ready = (level_q != FULL);
    assign push     = in_valid && in_ready;
    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign out_req  = req_q;
    assign out_data = data_q;
    assign level    = level_q;
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= in_data;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // out_ack is asynchronous to clk; only ack_s is ever used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], out_ack};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
            req_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            req_q   <= req_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        // Outside WAIT_ACK the channel must be quiescent.
        err_d   = err_q | ((state_q != WAIT_ACK) && (ack_s != req_q));
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    data_d  = mem_q[rptr_q];
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = ~req_q;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_s == req_q) begin
                    if (level_q != '0) begin
                        data_d  = mem_q[rptr_q];
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_to_click_tx.sv
// Directed bench for sync_to_click_tx with a 2-phase ack responder
// that can also inject spurious ack toggles.
module tb_sync_to_click_tx;

    localparam int DW = 7;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [DW:0] in_data;
    logic        out_req;
    logic [DW:0] out_data;
    logic        out_ack = 1'b0;
    logic [2:0]  level;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int stab_viol = 0;

    bit resp_en = 1'b0;
    int dly_lo = 0;
    int dly_hi = 0;
    int spur_cnt = 0;
    int spur_done = 0;
    int rcnt = 0;
    int rdly = 0;

    logic [DW:0] rx_q[$];

    sync_to_click_tx #(
        .DATA_WIDTH (DW),
        .DEPTH      (4),
        .SYNC_STAGES(SS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .out_req (out_req),
        .out_data(out_data),
        .out_ack (out_ack),
        .level   (level),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Click-stage model: answers each req after a random delay.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            out_ack = 1'b0;
            rcnt    = 0;
        end else if (spur_done != spur_cnt) begin
            out_ack   = ~out_ack;
            spur_done = spur_cnt;
        end else if (resp_en && out_req != out_ack) begin
            if (rcnt == 0) rdly = $urandom_range(dly_hi, dly_lo);
            rcnt++;
            if (rcnt > rdly) begin
                out_ack = out_req;
                rcnt    = 0;
            end
        end else begin
            rcnt = 0;
        end
    end

    always @(out_req) begin
        if (rst !== 1'b1) rx_q.push_back(out_data);
    end

    always @(out_data) begin
        if (rst !== 1'b1 && out_req !== out_ack) stab_viol++;
    end

    task automatic push_word(input logic [DW:0] d);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int stable = 0;
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (level == 3'd0 && out_req == out_ack) stable++;
            else stable = 0;
            if (stable >= SS + 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        resp_en  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(posedge clk); #1;
        in_data  = 8'h6B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_req: got %0b want 1", out_req);
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (out_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req: got %0b want 0", out_req);
        end
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_data: got %h want 00", out_data);
        end
        n_checks++;
        if (level !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_level: got %0d want 0", level);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err: got %0b want 0", err);
        end
        @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        rx_q.delete();
        dly_lo  = 2;
        dly_hi  = 2;
        resp_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (level !== 3'd1 || out_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n: got level %0d req %0b want 1 0", level, out_req);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_data !== 8'hA5 || out_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n1: got data %h req %0b want a5 0", out_data, out_req);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_req !== 1'b1) begin
            n_fail++;
            $display("FAIL single_n2_req: got %0b want 1", out_req);
        end
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL single_drain: got timeout want done");
        end
        n_checks++;
        if (rx_q.size() != 1 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL single_count: got %0d words level %0d want 1 0", rx_q.size(), level);
        end else if (rx_q[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_word: got %h want a5", rx_q[0]);
        end
    endtask

    task automatic test_fill();
        bit ok;
        rx_q.delete();
        resp_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(posedge clk); #1;
        end
        n_checks++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got level %0d ready %0b want 4 0", level, in_ready);
        end
        n_checks++;
        if (out_data !== 8'h01) begin
            n_fail++;
            $display("FAIL fill_head: got %h want 01", out_data);
        end
        in_data = 8'h06;
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_hold: got level %0d ready %0b want 4 0", level, in_ready);
        end
        dly_lo  = 0;
        dly_hi  = 2;
        resp_en = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1 || rx_q.size() != 5) begin
            n_fail++;
            $display("FAIL fill_count: got %0d words want 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (rx_q[i] !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL fill_order[%0d]: got %h want %h", i, rx_q[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_simul_push_pop();
        bit ok;
        logic [DW:0] exp [4];
        exp[0] = 8'h11;
        exp[1] = 8'h22;
        exp[2] = 8'h33;
        exp[3] = 8'h44;
        rx_q.delete();
        resp_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = exp[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (level !== 3'd2) begin
            n_fail++;
            $display("FAIL simul_pre: got level %0d want 2", level);
        end
        #3;
        dly_lo  = 0;
        dly_hi  = 0;
        resp_en = 1'b1;
        // ack toggles after the 1st edge; ack_s matches after the 3rd
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = exp[3];
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (level !== 3'd2) begin
            n_fail++;
            $display("FAIL simul_level: got %0d want 2", level);
        end
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1 || rx_q.size() != 4) begin
            n_fail++;
            $display("FAIL simul_count: got %0d words want 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (rx_q[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL simul_order[%0d]: got %h want %h", i, rx_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        rx_q.delete();
        dly_lo  = 0;
        dly_hi  = 5;
        resp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int g;
            push_word(8'(i));
            g = $urandom_range(3, 0);
            for (int k = 0; k < g; k++) begin
                @(posedge clk); #1;
            end
        end
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1 || rx_q.size() != 20) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d words want 20", rx_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_checks++;
                if (rx_q[i] !== 8'(i)) begin
                    n_fail++;
                    $display("FAIL wrap_order[%0d]: got %h want %h", i, rx_q[i], 8'(i));
                end
            end
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_err: got %0b want 0", err);
        end
        n_checks++;
        if (stab_viol != 0) begin
            n_fail++;
            $display("FAIL data_stable: got %0d changes want 0", stab_viol);
        end
    endtask

    task automatic test_fault_spurious();
        bit ok;
        rx_q.delete();
        resp_en = 1'b0;
        #3 spur_cnt++;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_early: got %0b want 0", err);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_err: got %0b want 1", err);
        end
        #3 spur_cnt++;
        repeat (5) begin
            @(posedge clk); #1;
        end
        dly_lo  = 1;
        dly_hi  = 3;
        resp_en = 1'b1;
        push_word(8'h3C);
        push_word(8'hC3);
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1 || rx_q.size() != 2) begin
            n_fail++;
            $display("FAIL spur_count: got %0d words want 2", rx_q.size());
        end else if (rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3) begin
            n_fail++;
            $display("FAIL spur_words: got %h %h want 3c c3", rx_q[0], rx_q[1]);
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_sticky: got %0b want 1", err);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        rx_q.delete();
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hE0 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL rmid_pre: got level %0d want 3", level);
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (level !== 3'd0 || out_req !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_clear: got level %0d req %0b err %0b want 0 0 0", level, out_req, err);
        end
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        rx_q.delete();
        dly_lo  = 0;
        dly_hi  = 2;
        resp_en = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (rx_q.size() != 0 || level !== 3'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_stale: got %0d words level %0d err %0b want 0 0 0", rx_q.size(), level, err);
        end
        push_word(8'h77);
        wait_drain(ok);
        n_checks++;
        if (ok !== 1'b1 || rx_q.size() != 1) begin
            n_fail++;
            $display("FAIL rmid_count: got %0d words want 1", rx_q.size());
        end else if (rx_q[0] !== 8'h77) begin
            n_fail++;
            $display("FAIL rmid_word: got %h want 77", rx_q[0]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_single();
        test_fill();
        test_simul_push_pop();
        test_wrap();
        test_fault_spurious();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
